// File: rtl/uart_tx_pkg.sv
// Shared UART TX types: frame FSM state encoding and line-level constants.
// Pure declarations; no logic, no timing.
package uart_tx_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Byte-in / serializer / line bundle for the UART TX frame controller.
// master = upstream plus serializer side, slave = the controller.
interface uart_tx_ctrl_if
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
  logic                  data_valid;
  logic [DATA_WIDTH-1:0] p_data;
  logic                  par_en;
  logic                  par_typ;
  logic                  ser_data;
  logic                  ser_done;
  logic                  ser_en;
  logic                  tx_out;
  logic                  busy;
  logic                  frame_err;

  modport master (
    output data_valid, p_data, par_en, par_typ, ser_data, ser_done,
    input  ser_en, tx_out, busy, frame_err
  );

  modport slave (
    input  data_valid, p_data, par_en, par_typ, ser_data, ser_done,
    output ser_en, tx_out, busy, frame_err
  );
endinterface

// File: rtl/uart_parity_calc.sv
// Parity of a data word, even (odd=0) or odd (odd=1); purely combinational.
// Zero latency, no backpressure.
module uart_parity_calc #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  odd,
  output logic                  parity
);
  always_comb begin
    parity = (^data) ^ odd;
  end
endmodule

// File: rtl/uart_tx_ctrl.sv
// UART TX frame FSM: start, serializer data, optional parity, stop bits; one bit per clk.
// tx_out/busy registered (line lags state by one cycle); bytes offered while busy are dropped.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int STOP_BITS  = 1,
  parameter int WD_LIMIT   = 10
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_ctrl_if.slave  bus
);
  localparam int WD_W = $clog2(WD_LIMIT + 1);

  state_t            state_q, state_d;
  logic              par_en_q, par_en_d;
  logic              parity_q, parity_d;
  logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
  logic [1:0]        stop_cnt_q, stop_cnt_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              frame_err_q, frame_err_d;
  logic              ser_en;
  logic              parity_new;
  logic              accept;
  logic              wd_expire;
  logic              stop_last;

  uart_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
    .data   (bus.p_data),
    .odd    (bus.par_typ),
    .parity (parity_new)
  );

  assign wd_expire = (wd_cnt_q == WD_W'(WD_LIMIT - 1));
  assign stop_last = (stop_cnt_q == 2'(STOP_BITS - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      par_en_q    <= 1'b0;
      parity_q    <= 1'b0;
      wd_cnt_q    <= '0;
      stop_cnt_q  <= '0;
      tx_q        <= LINE_IDLE;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      par_en_q    <= par_en_d;
      parity_q    <= parity_d;
      wd_cnt_q    <= wd_cnt_d;
      stop_cnt_q  <= stop_cnt_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    par_en_d   = par_en_q;
    parity_d   = parity_q;
    wd_cnt_d   = wd_cnt_q;
    stop_cnt_d = stop_cnt_q;
    accept     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.data_valid) begin
          state_d = START;
          accept  = 1'b1;
        end
      end
      START: begin
        state_d  = DATA;
        wd_cnt_d = '0;
      end
      DATA: begin
        wd_cnt_d = wd_cnt_q + 1'b1;
        // ser_done outranks a watchdog expiring in the same cycle
        if (bus.ser_done) begin
          state_d    = par_en_q ? PARITY : STOP;
          wd_cnt_d   = '0;
          stop_cnt_d = '0;
        end else if (wd_expire) begin
          state_d    = STOP;
          wd_cnt_d   = '0;
          stop_cnt_d = '0;
        end
      end
      PARITY: begin
        state_d    = STOP;
        stop_cnt_d = '0;
      end
      STOP: begin
        if (stop_last) begin
          stop_cnt_d = '0;
          if (bus.data_valid) begin
            state_d = START;
            accept  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          stop_cnt_d = stop_cnt_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      par_en_d = bus.par_en;
      parity_d = parity_new;
    end
  end

  always_comb begin
    ser_en      = (state_q == START) || (state_q == DATA);
    busy_d      = (state_d != IDLE);
    frame_err_d = (state_q == DATA) && !bus.ser_done && wd_expire;
    case (state_q)
      START:   tx_d = LINE_START;
      DATA:    tx_d = bus.ser_data;
      PARITY:  tx_d = parity_q;
      default: tx_d = LINE_IDLE;
    endcase
  end

  assign bus.ser_en    = ser_en;
  assign bus.tx_out    = tx_q;
  assign bus.busy      = busy_q;
  assign bus.frame_err = frame_err_q;

endmodule
